// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S slave receiver.
package i2s_pkg;

   localparam int CNT_W = 6;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {SEEK, RUN} rx_state_t;
   typedef enum logic {CH_LEFT = 1'b0, CH_RIGHT = 1'b1} i2s_ch_t;

endpackage

// File: rtl/i2s_sync.sv
// Single-bit multi-flop synchronizer with registered rise/fall strobes
// derived from the synchronized level.
module i2s_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   rise_q;
   logic                   fall_q;

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         prev_q <= sync_q[SYNC_STAGES-1];
         rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
         fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
      end
   end

   assign level_o = sync_q[SYNC_STAGES-1];
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver: synchronizes sclk/ws/sdi, deserializes MSB-first words
// and presents left/right pairs on a valid/ready interface with a sticky overrun flag.
module i2s_rx
   import i2s_pkg::*;
#(
   parameter int WIDTH       = 16,  // 8..32
   parameter int SYNC_STAGES = 2    // >= 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             sclk,
   input  logic             ws,
   input  logic             sdi,
   output logic [WIDTH-1:0] out_left,
   output logic [WIDTH-1:0] out_right,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             ovr,
   input  logic             ovr_clr
);

   logic sclk_lvl, sclk_rise, sclk_fall;
   logic ws_s, ws_rise, ws_fall;
   logic sdi_s, sdi_rise, sdi_fall;

   i2s_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk(clk), .reset_n(reset_n), .d_i(sclk),
      .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));
   i2s_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ws (
      .clk(clk), .reset_n(reset_n), .d_i(ws),
      .level_o(ws_s), .rise_o(ws_rise), .fall_o(ws_fall));
   i2s_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
      .clk(clk), .reset_n(reset_n), .d_i(sdi),
      .level_o(sdi_s), .rise_o(sdi_rise), .fall_o(sdi_fall));

   logic unused_edges;
   assign unused_edges = ^{sclk_lvl, sclk_fall, ws_rise, ws_fall, sdi_rise, sdi_fall};

   rx_state_t        state_q, state_d;
   i2s_ch_t          ws_prev_q, ws_prev_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             left_ok_q, left_ok_d;
   logic [WIDTH-1:0] left_hold_q, left_hold_d;
   logic [WIDTH-1:0] out_left_q, out_left_d;
   logic [WIDTH-1:0] out_right_q, out_right_d;
   logic             out_valid_q, out_valid_d;
   logic             ovr_q, ovr_d;

   logic             boundary;
   logic             frame_done;
   logic             overrun;
   logic [WIDTH-1:0] word_in;

   // A boundary rise carries the LSB of the word for channel ws_prev.
   assign boundary = sclk_rise && (i2s_ch_t'(ws_s) != ws_prev_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= SEEK;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!en)                            state_d = SEEK;
      else if (state_q == SEEK && boundary) state_d = RUN;
   end

   always_comb begin
      // NOTE: every target gets a default first so no path leaves a latch behind.
      ws_prev_d   = ws_prev_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      left_ok_d   = left_ok_q;
      left_hold_d = left_hold_q;
      out_left_d  = out_left_q;
      out_right_d = out_right_q;
      out_valid_d = out_valid_q;
      frame_done  = 1'b0;
      overrun     = 1'b0;

      // Current word with this rise's bit placed MSB-justified; bits past WIDTH fall off.
      word_in = shift_q;
      for (int i = 0; i < WIDTH; i++) begin
         if (int'(cnt_q) == WIDTH - 1 - i) word_in[i] = sdi_s;
      end

      if (sclk_rise) ws_prev_d = i2s_ch_t'(ws_s);

      if (!en) begin
         shift_d   = '0;
         cnt_d     = '0;
         left_ok_d = 1'b0;
      end else if (state_q == SEEK) begin
         if (boundary) begin
            shift_d   = '0;
            cnt_d     = '0;
            left_ok_d = 1'b0;
         end
      end else if (sclk_rise) begin
         if (boundary) begin
            shift_d = '0;
            cnt_d   = '0;
            if (ws_prev_q == CH_LEFT) begin
               left_hold_d = word_in;
               left_ok_d   = 1'b1;
            end else if (left_ok_q) begin
               frame_done = 1'b1;
               left_ok_d  = 1'b0;
            end
         end else begin
            shift_d = word_in;
            cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
         end
      end

      if (frame_done) begin
         if (!out_valid_q || out_ready) begin
            out_left_d  = left_hold_q;
            out_right_d = word_in;
            out_valid_d = 1'b1;
         end else begin
            overrun = 1'b1;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      ovr_d = ovr_clr ? 1'b0 : (ovr_q | overrun);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ws_prev_q   <= CH_LEFT;
         shift_q     <= '0;
         cnt_q       <= '0;
         left_ok_q   <= 1'b0;
         left_hold_q <= '0;
         out_left_q  <= '0;
         out_right_q <= '0;
         out_valid_q <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         ws_prev_q   <= ws_prev_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         left_ok_q   <= left_ok_d;
         left_hold_q <= left_hold_d;
         out_left_q  <= out_left_d;
         out_right_q <= out_right_d;
         out_valid_q <= out_valid_d;
         ovr_q       <= ovr_d;
      end
   end

   assign out_left  = out_left_q;
   assign out_right = out_right_q;
   assign out_valid = out_valid_q;
   assign ovr       = ovr_q;

endmodule
